// File: rtl/mmio_timer_if.sv
// CPU memory-bus view of the timer window: chip select, write enable, word address and shared data.
// The shared data bus is resolved here from the two drive enables, so either side's drive is observable.
interface mmio_timer_if;
  logic        cs;
  logic        we;
  logic [6:0]  addr;
  logic [31:0] cpu_dat;
  logic        cpu_oe;
  logic [31:0] dev_dat;
  logic        dev_oe;
  logic [31:0] mem_bus;

  // Timer drive has priority; with no driver the bus floats to zero in this two-state view.
  assign mem_bus = dev_oe ? dev_dat : (cpu_oe ? cpu_dat : 32'd0);

  modport master (output cs, we, addr, cpu_dat, cpu_oe, input dev_dat, dev_oe, mem_bus);
  modport slave  (input cs, we, addr, mem_bus, output dev_dat, dev_oe);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled countdown timer on the RAM bus; bus sampled on negedge, state updated on posedge.
// Read data lands the same cycle a RAM word would; irq is registered one cycle behind expired/irq_en.
module mmio_timer #(
  parameter logic [6:0]  BASE_ADDR = 7'h7C,
  parameter int unsigned PRESCALE  = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  mmio_timer_if.slave  bus,
  output logic         irq_o
);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic             sel;
  logic [31:0]      rd_mux;
  logic [31:0]      rd_data_q;
  logic             wr_pend_q;
  logic [1:0]       wr_idx_q;
  logic [31:0]      wr_dat_q;
  logic             en_q, en_d, reload_q, reload_d, irq_en_q, irq_en_d;
  logic             expired_q, expired_d, irq_q;
  logic [CNT_W-1:0] load_q, load_d, count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;

  assign sel         = bus.cs && (bus.addr[6:2] == BASE_ADDR[6:2]);
  assign bus.dev_oe  = sel && !bus.we && !rst;
  assign bus.dev_dat = rd_data_q;
  assign irq_o       = irq_q;

  always_comb begin
    rd_mux = '0;
    case (bus.addr[1:0])
      2'd0:    rd_mux = {29'd0, irq_en_q, reload_q, en_q};
      2'd1:    rd_mux = 32'(load_q);
      2'd2:    rd_mux = 32'(count_q);
      default: rd_mux = {31'd0, expired_q};
    endcase
  end

  // Bus side: capture on the falling edge so the access is ready for the next rising edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      wr_dat_q  <= '0;
    end else begin
      wr_pend_q <= sel && bus.we;
      if (sel && bus.we) begin
        wr_idx_q <= bus.addr[1:0];
        wr_dat_q <= bus.mem_bus;
      end
      if (sel && !bus.we) rd_data_q <= rd_mux;
    end
  end

  assign tick = en_q && (pre_q == PRE_MAX);

  // Ordering encodes the collision rules: W1C before expiry set, register writes after tick effects.
  always_comb begin
    en_d      = en_q;
    reload_d  = reload_q;
    irq_en_d  = irq_en_q;
    expired_d = expired_q;
    load_d    = load_q;
    count_d   = count_q;
    pre_d     = (en_q && !tick) ? pre_q + PW'(1) : '0;

    if (wr_pend_q && wr_idx_q == 2'd3 && wr_dat_q[0]) expired_d = 1'b0;

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        expired_d = 1'b1;
        if (reload_q) count_d = load_q;
        else          en_d    = 1'b0;
      end
    end

    if (wr_pend_q && wr_idx_q == 2'd0) {irq_en_d, reload_d, en_d} = wr_dat_q[2:0];

    if (wr_pend_q && wr_idx_q == 2'd1) begin
      load_d  = CNT_W'(wr_dat_q);
      count_d = CNT_W'(wr_dat_q);
      pre_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      reload_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      expired_q <= 1'b0;
      load_q    <= '0;
      count_q   <= '0;
      pre_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      reload_q  <= reload_d;
      irq_en_q  <= irq_en_d;
      expired_q <= expired_d;
      load_q    <= load_d;
      count_q   <= count_d;
      pre_q     <= pre_d;
      irq_q     <= expired_q && irq_en_q;
    end
  end
endmodule
